// File: rtl/pri_arbiter8.sv
// pri_arbiter8 - eight-way arbiter for one shared downstream resource.
//
// Selects a winner by fixed priority (highest index) or round-robin
// (searching downward from a rotating pointer), then holds the grant until
// the owner releases it, drops its request, the arbiter is disabled, or the
// grant reaches MAX_HOLD cycles (MAX_HOLD = 0 disables the timeout).
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   en         enable; low blocks new grants and force-releases a grant
//   mode       0 = fixed priority, 1 = round-robin (sampled at grant time)
//   req[7:0]   request vector, one bit per requester
//   done       owner releases the resource (ignored while idle)
//   gnt[7:0]   registered one-hot grant, zero when idle
//   gnt_id     registered binary owner index, zero when idle
//   gnt_valid  registered, equals |gnt
//   timeout    registered one-cycle pulse after a hold-limit revocation
module pri_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       mode,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
    localparam logic       HOLD_EN  = (MAX_HOLD != 32'd0);

    logic [0:0] state_r, state_s;
    logic [7:0] gnt_r, gnt_s;
    logic [2:0] gnt_id_r, gnt_id_s;
    logic       gnt_valid_r, gnt_valid_s;
    logic       timeout_r, timeout_s;
    logic [7:0] cnt_r, cnt_s;
    logic [2:0] ptr_r, ptr_s;
    logic [2:0] win_s;

    // Search order: fixed mode scans 7 down to 0; round-robin scans from
    // ptr downward with 3-bit wrap. The first set request wins.
    function automatic logic [2:0] pick_winner(input logic [7:0] r,
                                               input logic       rr,
                                               input logic [2:0] p);
        logic [2:0] w;
        logic [2:0] idx;
        logic       found;
        w     = 3'd0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rr) begin
                idx = p - 3'(i);
            end else begin
                idx = 3'(7 - i);
            end
            if (!found && r[idx]) begin
                w     = idx;
                found = 1'b1;
            end else begin
                w     = w;
            end
        end
        return w;
    endfunction

    // Next-state and next-output computation for the IDLE/BUSY controller.
    always_comb begin
        state_s     = state_r;
        gnt_s       = gnt_r;
        gnt_id_s    = gnt_id_r;
        gnt_valid_s = gnt_valid_r;
        cnt_s       = cnt_r;
        ptr_s       = ptr_r;
        timeout_s   = 1'b0;
        win_s       = pick_winner(req, mode, ptr_r);

        case (state_r)
            IDLE: begin
                if (en && (req != 8'd0)) begin
                    state_s     = BUSY;
                    gnt_s       = 8'd1 << win_s;
                    gnt_id_s    = win_s;
                    gnt_valid_s = 1'b1;
                    cnt_s       = 8'd1;
                    // Pointer tracks the last winner in both modes.
                    ptr_s       = win_s - 3'd1;
                end else begin
                    gnt_s       = 8'd0;
                    gnt_id_s    = 3'd0;
                    gnt_valid_s = 1'b0;
                end
            end
            BUSY: begin
                // Release priority: disable, then owner release, then hold limit.
                if (!en || done || !req[gnt_id_r] ||
                    (HOLD_EN && (cnt_r == HOLD_LIM))) begin
                    state_s     = IDLE;
                    gnt_s       = 8'd0;
                    gnt_id_s    = 3'd0;
                    gnt_valid_s = 1'b0;
                    cnt_s       = 8'd0;
                    timeout_s   = en && !done && req[gnt_id_r];
                end else if (cnt_r != 8'hFF) begin
                    cnt_s = cnt_r + 8'd1;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s     = IDLE;
                gnt_s       = 8'd0;
                gnt_id_s    = 3'd0;
                gnt_valid_s = 1'b0;
                cnt_s       = 8'd0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            gnt_r       <= 8'd0;
            gnt_id_r    <= 3'd0;
            gnt_valid_r <= 1'b0;
            timeout_r   <= 1'b0;
            cnt_r       <= 8'd0;
            ptr_r       <= 3'd7;
        end else begin
            state_r     <= state_s;
            gnt_r       <= gnt_s;
            gnt_id_r    <= gnt_id_s;
            gnt_valid_r <= gnt_valid_s;
            timeout_r   <= timeout_s;
            cnt_r       <= cnt_s;
            ptr_r       <= ptr_s;
        end
    end

    assign gnt       = gnt_r;
    assign gnt_id    = gnt_id_r;
    assign gnt_valid = gnt_valid_r;
    assign timeout   = timeout_r;

endmodule

// File: tb/tb_pri_arbiter8.sv
// Directed testbench for pri_arbiter8 (MAX_HOLD = 4).
module tb_pri_arbiter8;

    logic       clk;
    logic       rst;
    logic       en;
    logic       mode;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int n_cmp;
    int n_bad;

    pri_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the full output set against one expected grant state.
    task automatic expect_out(input string tag, input logic [7:0] g,
                              input logic [2:0] id, input logic v,
                              input logic to);
        check({tag, ".gnt"},       32'(gnt),       32'(g));
        check({tag, ".gnt_id"},    32'(gnt_id),    32'(id));
        check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(v));
        check({tag, ".timeout"},   32'(timeout),   32'(to));
    endtask

    logic [2:0] rr_seq [9];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rr_seq = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
        rst  = 1'b0;
        en   = 1'b0;
        mode = 1'b0;
        req  = 8'd0;
        done = 1'b0;
        #1 rst = 1'b1;
        #2;
        expect_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Fixed priority: highest index of 0010_0100 is 5.
        en  = 1'b1;
        req = 8'b0010_0100;
        tick();
        expect_out("fixed_grant", 8'b0010_0000, 3'd5, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        expect_out("done_release", 8'h00, 3'd0, 1'b0, 1'b0);
        done = 1'b0;
        tick();
        expect_out("fixed_regrant", 8'b0010_0000, 3'd5, 1'b1, 1'b0);
        req = 8'd0;
        tick();
        expect_out("req_drop", 8'h00, 3'd0, 1'b0, 1'b0);

        // Fresh reset so the round-robin pointer starts at 7.
        @(negedge clk);
        rst = 1'b1;
        #1 rst = 1'b0;
        mode = 1'b1;
        req  = 8'hFF;
        done = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            expect_out($sformatf("rr_grant%0d", i), 8'd1 << rr_seq[i], rr_seq[i], 1'b1, 1'b0);
            tick();
            check($sformatf("rr_idle%0d", i), 32'(gnt), 32'd0);
        end

        // Hold limit 4: four grant cycles, then one timeout cycle.
        mode = 1'b0;
        done = 1'b0;
        req  = 8'b0000_1000;
        for (int c = 1; c <= 4; c++) begin
            tick();
            expect_out($sformatf("hold_c%0d", c), 8'b0000_1000, 3'd3, 1'b1, 1'b0);
        end
        tick();
        expect_out("timeout_pulse", 8'h00, 3'd0, 1'b0, 1'b1);
        tick();
        expect_out("timeout_regrant", 8'b0000_1000, 3'd3, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        expect_out("hold2_c4", 8'b0000_1000, 3'd3, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        expect_out("done_at_limit", 8'h00, 3'd0, 1'b0, 1'b0);
        done = 1'b0;

        // Forced release by en in requester 6's second grant cycle.
        req = 8'b0100_0000;
        tick();
        expect_out("en_grant6", 8'b0100_0000, 3'd6, 1'b1, 1'b0);
        tick();
        expect_out("en_c2", 8'b0100_0000, 3'd6, 1'b1, 1'b0);
        en = 1'b0;
        tick();
        expect_out("en_forced", 8'h00, 3'd0, 1'b0, 1'b0);
        req = 8'hFF;
        tick();
        tick();
        expect_out("en_low_block", 8'h00, 3'd0, 1'b0, 1'b0);
        en = 1'b1;
        tick();
        expect_out("en_regrant", 8'b1000_0000, 3'd7, 1'b1, 1'b0);

        // Asynchronous reset mid-grant clears outputs before any edge.
        mode = 1'b1;
        #2 rst = 1'b1;
        #1;
        expect_out("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        tick();
        expect_out("post_rst_ptr", 8'b1000_0000, 3'd7, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pri_arbiter8.md
# pri_arbiter8

Eight-way bus arbiter that shares one downstream resource between eight requesters. Winner selection is fixed-priority (highest index wins, the same ordering as our 8-to-3 priority encoder) or round-robin, chosen by `mode`. The grant is held until the owner releases it, drops its request, or exceeds a hold limit. The block sits between the requesters and the shared resource and drives its select lines (`gnt`, `gnt_id`).

## Interface
- `MAX_HOLD`, default 16: maximum grant length in cycles. Legal range 0..255. 0 disables the timeout.
- `clk` input 1: clock. All state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: arbiter enable. Low blocks new grants and force-releases any current grant.
- `mode` input 1: 0 = fixed priority, 1 = round-robin. Sampled only when a grant is issued.
- `req` input 8: request vector, one bit per requester.
- `done` input 1: the current owner releases the resource. Ignored when no grant is active.
- `gnt` output 8: one-hot grant. All zero when idle.
- `gnt_id` output 3: binary index of the owner. 0 when idle.
- `gnt_valid` output 1: a grant is active. Equals `|gnt`.
- `timeout` output 1: one-cycle pulse when a grant is revoked because it reached `MAX_HOLD`.

## Operation
- Reset, asynchronous: state=IDLE; `gnt`=0, `gnt_id`=0, `gnt_valid`=0, `timeout`=0; hold counter=0; round-robin pointer `ptr`=7.
- All outputs are registered.
- Winner selection:
  - Fixed mode: highest set index of `req`.
  - Round-robin mode: search `ptr`, `ptr`-1, …, 0, then 7, … downward with mod-8 wrap; the first set bit wins.
  - On every grant, in either mode, `ptr` ← (winner − 1) mod 8. Winner 0 gives `ptr`=7.
- IDLE state:
  - If `en` && `req`≠0: load `gnt`=onehot(winner), `gnt_id`=winner, `gnt_valid`=1, hold counter=1, go to BUSY.
  - Otherwise stay in IDLE with outputs at zero.
  - `timeout` is cleared in every IDLE cycle that it did not just pulse.
- BUSY state. Release causes are checked in this order:
  1. `en`=0: forced release, `timeout` stays 0.
  2. `done`=1 or `req[gnt_id]`=0: normal release.
  3. `MAX_HOLD`≠0 and counter==`MAX_HOLD`: timeout release, `timeout`←1.
  4. Otherwise: counter increments (8-bit, saturating at 255) and the grant is held.
- Any release clears `gnt`, `gnt_id` and `gnt_valid` and moves to IDLE.
- Changes on other `req` bits during BUSY are ignored; there is no preemption.
- `mode` changes during BUSY take effect at the next grant.
- `ptr` is updated in both modes, so switching to round-robin continues from the last winner.

## Timing
- Grant latency: `req` sampled at edge E makes `gnt` valid after E, i.e. 1 cycle.
- Release latency: `done` seen at edge E clears `gnt` after E.
- There is always exactly one IDLE cycle between consecutive grants. Earliest regrant is at edge E+1, so `gnt` is low for exactly one cycle.
- Timeout with `MAX_HOLD`=N:
  - `gnt` is high for exactly N cycles.
  - `timeout` is high for exactly one cycle, the IDLE cycle in which `gnt`=0.
  - The same requester may be regranted on the next edge. In round-robin mode, other active requesters take precedence.
- Simultaneous `done` and counter==`MAX_HOLD`: normal release, no `timeout`.
- Simultaneous `en` low and `done`: forced release, no `timeout`. The observable result is the same as a normal release.
- `rst` mid-grant: outputs clear immediately, without waiting for a clock edge. The first grant after `rst` falls is on the first edge where `en`&&`req`≠0.
- `MAX_HOLD`=1: each grant lasts one cycle, and a requester that did not release gets a `timeout` pulse.

## Test plan
- Fixed mode, `en`=1, `req`=8'b0010_0100 from IDLE → after 1 edge: `gnt`=8'b0010_0000, `gnt_id`=5, `gnt_valid`=1.
- Continuing the first test, `done`=1 for one cycle with `req` unchanged → next cycle `gnt`=0. The following cycle `gnt`=8'b0010_0000 again (fixed mode: 5 still wins).
- Round-robin mode, `req`=8'hFF held, `done` pulsed each grant cycle → `gnt_id` sequence 7,6,5,4,3,2,1,0,7, with one idle cycle between each.
- `MAX_HOLD`=4, fixed mode, `req`=8'b0000_1000 held, `done`=0:
  - `gnt_id`=3 for 4 cycles, then `gnt`=0 with `timeout`=1 for 1 cycle.
  - Regrant to 3 on the next cycle.
  - Repeat with `done` asserted in cycle 4 → no `timeout`.
- `en` dropped in the 2nd grant cycle of requester 6 → next cycle `gnt`=0, `timeout`=0. While `en`=0 with `req`=8'hFF, no grant is issued. Raising `en` → grant after 1 edge.
- `rst` pulsed asynchronously mid-grant in round-robin mode → `gnt`, `gnt_id`, `gnt_valid`, `timeout` go to 0 before the next edge. After release with `req`=8'hFF, the first `gnt_id` is 7, proving `ptr` was reset.
